// File: rtl/xnor3_bist.sv
`default_nettype none
// ============================================================================
// Module   : xnor3_bist
// Purpose  : Built-in self-test controller for a 3-input XNOR stage. It
//            steps {a,b,c} through all eight input combinations, checks the
//            returned y against ~(a^b^c), counts mismatches in a saturating
//            counter and records the first failing vector.
// Ports    : clk_i        rising-edge clock
//            reset_n_i    asynchronous active-low reset
//            start_i      run request, honoured only in IDLE or DONE
//            a_o/b_o/c_o  registered stimulus, {a,b,c} = current vector
//            y_i          XNOR stage output (combinational from a/b/c)
//            busy_o       high while the sweep is running
//            done_o       high once the run has finished
//            pass_o       high in DONE when no mismatch was seen
//            err_cnt_o    saturating mismatch count of the current run
//            fail_valid_o high once any mismatch has been seen this run
//            fail_vec_o   vector of the first mismatch, 0 if none
// Revision : 1.0  initial release
// ============================================================================
module xnor3_bist #(
  parameter int HOLD_CYCLES = 1,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             fail_valid_o,
  output logic [2:0]       fail_vec_o
);

  // Counters are sized for their terminal value; a width of at least one bit
  // keeps the degenerate HOLD_CYCLES=1 / PASSES=1 cases legal.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] C_PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [ERR_W-1:0]  C_ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [2:0]        C_VEC_LAST  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [2:0]        vec_q,        vec_d;
  logic [HOLD_W-1:0] hold_q,       hold_d;
  logic [PASS_W-1:0] pass_cnt_q,   pass_cnt_d;
  logic [ERR_W-1:0]  err_q,        err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [2:0]        fail_vec_q,   fail_vec_d;
  logic [2:0]        abc_q,        abc_d;

  logic              w_sample;
  logic              w_mismatch;

  // y is compared on the last hold cycle of a vector, so the stage has had
  // at least one full clock period to settle after a/b/c changed.
  assign w_sample   = (state_q == S_DRIVE) && (hold_q == C_HOLD_LAST);
  assign w_mismatch = (y_i != ~(^vec_q));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      vec_q        <= 3'd0;
      hold_q       <= '0;
      pass_cnt_q   <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
      abc_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      pass_cnt_q   <= pass_cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      abc_q        <= abc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    pass_cnt_d   = pass_cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    abc_d        = abc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Results stay visible in DONE until the next run clears them.
        if (start_i) begin
          state_d      = S_DRIVE;
          vec_d        = 3'd0;
          hold_d       = '0;
          pass_cnt_d   = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          abc_d        = 3'd0;
        end
      end

      S_DRIVE: begin
        if (!w_sample) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          if (w_mismatch) begin
            if (err_q != C_ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            // Only the first failing vector of the whole run is kept; later
            // sweeps still count their errors.
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end

          if (vec_q != C_VEC_LAST) begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
          end else if (pass_cnt_q != C_PASS_LAST) begin
            vec_d      = 3'd0;
            abc_d      = 3'd0;
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end else begin
            state_d = S_DONE;
            vec_d   = 3'd0;
            abc_d   = 3'd0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        abc_d   = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    a_o          = abc_q[2];
    b_o          = abc_q[1];
    c_o          = abc_q[0];
    busy_o       = (state_q == S_DRIVE);
    done_o       = (state_q == S_DONE);
    pass_o       = (state_q == S_DONE) && (err_q == '0);
    err_cnt_o    = err_q;
    fail_valid_o = fail_valid_q;
    fail_vec_o   = fail_vec_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_xnor3_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_xnor3_bist
// Purpose  : Self-checking bench for xnor3_bist. Three instances cover the
//            default configuration, a saturating multi-pass configuration
//            and a long-hold configuration. Each instance sees a bench-side
//            XNOR stage model that can be golden, stuck or inverted.
// Revision : 1.0  initial release
// ============================================================================
module tb_xnor3_bist;

  localparam logic [1:0] M_GOLD = 2'd0;
  localparam logic [1:0] M_SA0  = 2'd1;
  localparam logic [1:0] M_SA1  = 2'd2;
  localparam logic [1:0] M_INV  = 2'd3;

  typedef struct {
    int         err;
    logic [2:0] fvec;
    logic       fvalid;
    logic       pass;
    int         lat;
  } res_t;

  typedef struct packed {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fv;
    logic [2:0] fvec;
    logic [3:0] err;
  } st_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [1:0] mode0 = M_GOLD, mode1 = M_GOLD, mode2 = M_GOLD;

  logic a0, b0, c0, y0, busy0, done0, pass0, fv0;
  logic a1, b1, c1, y1, busy1, done1, pass1, fv1;
  logic a2, b2, c2, y2, busy2, done2, pass2, fv2;
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic [2:0] fvec0, fvec1, fvec2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_abc_q[$];
  res_t       exp_res_q[$];

  always #5 clk = ~clk;

  function automatic logic y_model(input logic [1:0] mode, input logic [2:0] v);
    case (mode)
      M_GOLD:  return ~(v[2] ^ v[1] ^ v[0]);
      M_SA0:   return 1'b0;
      M_SA1:   return 1'b1;
      default: return v[2] ^ v[1] ^ v[0];
    endcase
  endfunction

  always_comb y0 = y_model(mode0, {a0, b0, c0});
  always_comb y1 = y_model(mode1, {a1, b1, c1});
  always_comb y2 = y_model(mode2, {a2, b2, c2});

  xnor3_bist u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start0),
    .a_o(a0), .b_o(b0), .c_o(c0), .y_i(y0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .err_cnt_o(err0), .fail_valid_o(fv0), .fail_vec_o(fvec0)
  );

  xnor3_bist #(.HOLD_CYCLES(1), .PASSES(2), .ERR_W(2)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start1),
    .a_o(a1), .b_o(b1), .c_o(c1), .y_i(y1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .fail_valid_o(fv1), .fail_vec_o(fvec1)
  );

  xnor3_bist #(.HOLD_CYCLES(3), .PASSES(1), .ERR_W(4)) u_dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start2),
    .a_o(a2), .b_o(b2), .c_o(c2), .y_i(y2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .fail_valid_o(fv2), .fail_vec_o(fvec2)
  );

  function automatic st_t obs(input int i);
    st_t s;
    case (i)
      0:       s = '{abc: {a0, b0, c0}, busy: busy0, done: done0, pass: pass0,
                     fv: fv0, fvec: fvec0, err: err0};
      1:       s = '{abc: {a1, b1, c1}, busy: busy1, done: done1, pass: pass1,
                     fv: fv1, fvec: fvec1, err: {2'b00, err1}};
      default: s = '{abc: {a2, b2, c2}, busy: busy2, done: done2, pass: pass2,
                     fv: fv2, fvec: fvec2, err: err2};
    endcase
    return s;
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_mode(input int i, input logic [1:0] m);
    case (i)
      0:       mode0 = m;
      1:       mode1 = m;
      default: mode2 = m;
    endcase
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference result of one complete run, derived from the sweep definition.
  function automatic res_t model(input logic [1:0] mode, input int hold,
                                 input int passes, input int ew);
    res_t r;
    logic [2:0] vv;
    r.err = 0; r.fvec = 3'd0; r.fvalid = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 8; v++) begin
        vv = v[2:0];
        if (y_model(mode, vv) != ~(vv[2] ^ vv[1] ^ vv[0])) begin
          if (r.err < (1 << ew) - 1) r.err++;
          if (!r.fvalid) begin
            r.fvalid = 1'b1;
            r.fvec   = vv;
          end
        end
      end
    end
    r.pass = (r.err == 0);
    r.lat  = 8 * hold * passes;
    return r;
  endfunction

  task automatic pulse_start(input int i);
    @(negedge clk);
    set_start(i, 1'b1);
    @(posedge clk);
    #1;
    set_start(i, 1'b0);
  endtask

  task automatic run(input int i, input logic [1:0] mode, input int hold,
                     input int passes, input int ew, input bit mid_start);
    res_t r;
    st_t  s;
    int   cyc;
    set_mode(i, mode);
    exp_res_q.push_back(model(mode, hold, passes, ew));
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 8; v++)
        for (int h = 0; h < hold; h++)
          exp_abc_q.push_back(v[2:0]);

    pulse_start(i);
    cyc = 0;
    s = obs(i);
    check_eq("clr_err",    32'(s.err),  0);
    check_eq("clr_fvalid", 32'(s.fv),   0);
    check_eq("clr_fvec",   32'(s.fvec), 0);
    while (!s.done) begin
      check_eq("busy_run", 32'(s.busy), 1);
      if (exp_abc_q.size() == 0) check_eq("abc_overrun", cyc, 8 * hold * passes);
      else                       check_eq("abc", 32'(s.abc), 32'(exp_abc_q.pop_front()));
      set_start(i, mid_start && (cyc == 10));
      @(posedge clk);
      #1;
      cyc++;
      s = obs(i);
      if (cyc > 200) begin
        check_eq("done_timeout", cyc, 8 * hold * passes);
        break;
      end
    end
    set_start(i, 1'b0);
    check_eq("abc_left", exp_abc_q.size(), 0);
    exp_abc_q.delete();

    r = exp_res_q.pop_front();
    check_eq("latency", cyc, r.lat);
    check_eq("done",    32'(s.done), 1);
    check_eq("busy_end", 32'(s.busy), 0);
    check_eq("abc_end", 32'(s.abc), 0);
    check_eq("pass",    32'(s.pass), 32'(r.pass));
    check_eq("err_cnt", 32'(s.err), r.err);
    check_eq("fvalid",  32'(s.fv), 32'(r.fvalid));
    check_eq("fvec",    32'(s.fvec), 32'(r.fvec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    st_t s;
    int  cyc;

    // Reset values of every instance while reset is held.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_eq("reset_state", 32'(obs(i)), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run(0, M_GOLD, 1, 1, 4, 1'b0);   // golden sweep
    run(0, M_SA0,  1, 1, 4, 1'b0);   // y stuck at 0
    run(0, M_SA1,  1, 1, 4, 1'b0);   // y stuck at 1
    run(0, M_GOLD, 1, 1, 4, 1'b0);   // restart from DONE after a failing run
    run(1, M_INV,  1, 2, 2, 1'b0);   // every vector fails, counter saturates
    run(2, M_GOLD, 3, 1, 4, 1'b1);   // long hold with an ignored mid-run start

    // Asynchronous reset in the middle of a run.
    set_mode(0, M_GOLD);
    pulse_start(0);
    cyc = 0;
    while ({a0, b0, c0} != 3'd5 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("reach_vec5", 32'({a0, b0, c0}), 5);
    #1;
    reset_n = 1'b0;
    #1;
    s = obs(0);
    check_eq("async_rst_abc",  32'(s.abc), 0);
    check_eq("async_rst_busy", 32'(s.busy), 0);
    check_eq("async_rst_all",  32'(s), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 32'(obs(0)), 0);
    run(0, M_GOLD, 1, 1, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
